key_tone_ctrl: RTL and testbench
================================

KEY_TONE_CTRL -- requirements
Module: key_tone_ctrl

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of key inputs and divider-table entries (2..16).
REQ-002 Parameter DIV_W, default 20: width of the tone half-period divider.
REQ-003 Parameter VOL_W, default 8: width of the volume and PWM counter.
REQ-004 Parameter IDLE_TIMEOUT, default 1000000: idle cycles before auto-shutdown (used only with the Configuration feature).
REQ-005 Local IDX_W = max(1, clog2(NUM_KEYS)).
REQ-006 clk  in  1  system clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 keys  in  NUM_KEYS  asynchronous key levels; 1 = pressed.
REQ-009 volume  in  VOL_W  PWM duty; 0 = silent.
REQ-010 cfg_we  in  1  divider-table write strobe.
REQ-011 cfg_idx  in  IDX_W  table index to write.
REQ-012 cfg_div  in  DIV_W  half-period divider in clk cycles; 0 = key muted.
REQ-013 ain  out  1  registered audio PWM output.
REQ-014 gain  out  1  amplifier gain select, constant 1.
REQ-015 shutdown_l  out  1  amplifier enable, active-low shutdown.
REQ-016 playing  out  1  high while the FSM is in PLAY.
REQ-017 note_idx  out  IDX_W  index of the latched key.

Function
REQ-018 Each keys bit SHALL pass through a 2-flop synchroniser; only synchronised levels feed the FSM.
REQ-019 FSM states SHALL be IDLE and PLAY.
REQ-020 IDLE->PLAY SHALL occur when any synchronised key with a nonzero table divider is high; the lowest such index wins and is latched into note_idx.
REQ-021 A key with a zero divider SHALL be treated as not pressed.
REQ-022 PLAY->IDLE SHALL occur when the latched key's synchronised level is low; other keys SHALL be ignored in PLAY.
REQ-023 Latency SHALL be fixed: a key first sampled high at edge k gives playing=1 after edge k+2.
REQ-024 On entering PLAY, tone_cnt SHALL be 0 and tone_sq SHALL be 1.
REQ-025 tone_cnt SHALL count 0..div-1; at div-1 it SHALL wrap to 0 and toggle tone_sq, giving a tone period of 2*div cycles.
REQ-026 The divider in use SHALL be sampled from the table on PLAY entry and at every tone_cnt wrap.
REQ-027 pwm_cnt (VOL_W bits) SHALL free-run and wrap from all-ones to 0.
REQ-028 vol_lat SHALL load volume when pwm_cnt is all-ones.
REQ-029 pwm_hi SHALL be (pwm_cnt < vol_lat).
REQ-030 ain SHALL register playing & tone_sq & pwm_hi; it SHALL be 0 in IDLE and for the whole PWM frame while vol_lat = 0.
REQ-031 A cfg_we write SHALL update the table entry on the next edge.
REQ-032 A write with cfg_idx >= NUM_KEYS SHALL be ignored.
REQ-033 A write to the playing index SHALL affect the tone only at the next wrap.
REQ-034 A write that sets the playing entry to 0 SHALL NOT stop PLAY.
REQ-035 A write coinciding with PLAY entry SHALL NOT be seen by that entry; the entry uses the old value.

Reset
REQ-036 Reset SHALL clear synchronisers, FSM (IDLE), tone_cnt, tone_sq, pwm_cnt, vol_lat, all table entries to 0, and the idle counter.
REQ-037 Reset SHALL set ain=0, gain=1, shutdown_l=1, playing=0 and note_idx=0.
REQ-038 Reset asserted mid-PLAY SHALL force ain=0 immediately (asynchronously).

Configuration
REQ-039 With KEY_TONE_AUTO_SHUTDOWN_EN defined, an idle counter SHALL count consecutive IDLE cycles.
REQ-040 Under that macro, shutdown_l SHALL go 0 when the count reaches IDLE_TIMEOUT.
REQ-041 Under that macro, shutdown_l SHALL return to 1 on the same edge the FSM enters PLAY, and the counter SHALL clear.
REQ-042 Without the macro, shutdown_l SHALL be constant 1 and no idle counter SHALL exist.

Verification (NUM_KEYS=4, DIV_W=10, VOL_W=8)
REQ-043 Release reset -> ain=0, gain=1, shutdown_l=1, playing=0, note_idx=0; pressing any key leaves playing=0 (table empty).
REQ-044 Write idx1 div=5, volume=255, press key1 -> playing=1 two edges after first sample, note_idx=1; tone_sq period 10 cycles; ain high 255 of 256 cycles while tone_sq=1.
REQ-045 Program idx1=5 and idx2=7, press keys 1 and 2 together -> note_idx=1; release key2 -> still PLAY; release key1 -> IDLE, ain=0.
REQ-046 In PLAY change volume 255->64 -> new duty (64/256) from the next pwm_cnt wrap; volume 0 -> ain stuck 0.
REQ-047 Write idx1 div=9 while playing at div=5 -> current half-period completes at 5 cycles, then 9-cycle half-periods; rst_n low mid-PLAY -> all outputs at reset values at once.
REQ-048 With KEY_TONE_AUTO_SHUTDOWN_EN and IDLE_TIMEOUT=100 -> shutdown_l=0 after 100 idle cycles; press key1 -> shutdown_l=1 on the PLAY-entry edge.

Source files
------------

// File: rtl/key_tone_ctrl.sv
`timescale 1ns/1ps
// key_tone_ctrl
//   Turns a small bank of push keys into a square-wave tone for a PWM audio
//   amplifier. Each key has a programmable half-period divider. The lowest
//   pressed key with a nonzero divider is latched and played until that key
//   is released. The tone is gated by a free-running PWM whose duty is set by
//   volume and re-latched once per PWM frame.
//
//   Optional feature (macro KEY_TONE_AUTO_SHUTDOWN_EN): counts consecutive
//   idle cycles and pulls shutdown_l low after IDLE_TIMEOUT of them. It
//   releases shutdown_l on the edge that starts a new note. Without the macro,
//   shutdown_l is tied high and no idle counter is built.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   keys       in   [NUM_KEYS]  raw key levels, 1 = pressed
//   volume     in   [VOL_W]     PWM duty, 0 = silent
//   cfg_we     in   divider table write strobe
//   cfg_idx    in   [IDX_W]     table entry to write
//   cfg_div    in   [DIV_W]     half-period in clk cycles, 0 = key muted
//   ain        out  registered PWM audio
//   gain       out  amplifier gain select (tied 1)
//   shutdown_l out  amplifier enable, active-low shutdown
//   playing    out  high while a note is being played
//   note_idx   out  [IDX_W]     index of the latched key
module key_tone_ctrl #(
  parameter int NUM_KEYS     = 4,
  parameter int DIV_W        = 20,
  parameter int VOL_W        = 8,
  parameter int IDLE_TIMEOUT = 1000000,
  localparam int IDX_W       = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [VOL_W-1:0]    volume,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic                ain,
  output logic                gain,
  output logic                shutdown_l,
  output logic                playing,
  output logic [IDX_W-1:0]    note_idx
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0]    div_tab_q [NUM_KEYS];
  logic [DIV_W-1:0]    div_tab_d [NUM_KEYS];
  logic [IDX_W-1:0]    note_idx_q, note_idx_d;
  logic [DIV_W-1:0]    tone_cnt_q, tone_cnt_d;
  logic                tone_sq_q, tone_sq_d;
  logic [DIV_W-1:0]    cur_div_q, cur_div_d;
  logic [VOL_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [VOL_W-1:0]    vol_lat_q, vol_lat_d;
  logic                ain_q, ain_d;

  logic                cand_vld;
  logic [IDX_W-1:0]    cand_idx;
  logic                key_held;
  logic                enter_play;
  logic                pwm_hi;

  // Two-flop synchroniser; only sync2_q is ever looked at by the FSM.
  always_comb begin
    sync1_d = keys;
    sync2_d = sync1_q;
  end

  // Table write. An out-of-range index matches no entry, so it is dropped.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      div_tab_d[i] = (cfg_we && (cfg_idx == IDX_W'(i))) ? cfg_div : div_tab_q[i];
    end
  end

  // Priority pick. Scanning from the top lets the lowest live index win.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (sync2_q[i] && (div_tab_q[i] != '0)) begin
        cand_vld = 1'b1;
        cand_idx = IDX_W'(i);
      end
    end
  end

  assign key_held   = sync2_q[note_idx_q];
  assign enter_play = (state_q == IDLE) && cand_vld;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. In PLAY only the latched key matters. A muted divider
  // on that key does not end the note.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cand_vld) state_d = PLAY;
      PLAY:    if (!key_held) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and tone/PWM datapath.
  // The entry divider comes from the pre-write table, so a write that lands on
  // the entry edge only shows up at the first wrap.
  always_comb begin
    playing    = (state_q == PLAY);
    note_idx_d = note_idx_q;
    tone_cnt_d = tone_cnt_q;
    tone_sq_d  = tone_sq_q;
    cur_div_d  = cur_div_q;
    if (enter_play) begin
      note_idx_d = cand_idx;
      tone_cnt_d = '0;
      tone_sq_d  = 1'b1;
      cur_div_d  = div_tab_q[cand_idx];
    end else if ((state_q == PLAY) && (state_d == PLAY)) begin
      if (tone_cnt_q == (cur_div_q - DIV_W'(1))) begin
        tone_cnt_d = '0;
        tone_sq_d  = ~tone_sq_q;
        cur_div_d  = div_tab_q[note_idx_q];
      end else begin
        tone_cnt_d = tone_cnt_q + DIV_W'(1);
      end
    end else begin
      tone_cnt_d = '0;
      tone_sq_d  = 1'b0;
    end

    pwm_cnt_d = pwm_cnt_q + VOL_W'(1);
    vol_lat_d = (pwm_cnt_q == '1) ? volume : vol_lat_q;
    pwm_hi    = (pwm_cnt_q < vol_lat_q);
    ain_d     = playing & tone_sq_q & pwm_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      note_idx_q <= '0;
      tone_cnt_q <= '0;
      tone_sq_q  <= 1'b0;
      cur_div_q  <= '0;
      pwm_cnt_q  <= '0;
      vol_lat_q  <= '0;
      ain_q      <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) div_tab_q[i] <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      note_idx_q <= note_idx_d;
      tone_cnt_q <= tone_cnt_d;
      tone_sq_q  <= tone_sq_d;
      cur_div_q  <= cur_div_d;
      pwm_cnt_q  <= pwm_cnt_d;
      vol_lat_q  <= vol_lat_d;
      ain_q      <= ain_d;
      for (int i = 0; i < NUM_KEYS; i++) div_tab_q[i] <= div_tab_d[i];
    end
  end

  assign ain      = ain_q;
  assign note_idx = note_idx_q;
  assign gain     = 1'b1;

`ifdef KEY_TONE_AUTO_SHUTDOWN_EN
  localparam int IDLE_CW = $clog2(IDLE_TIMEOUT + 1);

  logic [IDLE_CW-1:0] idle_cnt_q, idle_cnt_d;
  logic               shutdown_l_q, shutdown_l_d;

  // Idle counter saturates at the timeout. A new note clears it and
  // re-enables the amplifier on the same edge.
  always_comb begin
    idle_cnt_d   = idle_cnt_q;
    shutdown_l_d = shutdown_l_q;
    if (enter_play) begin
      idle_cnt_d   = '0;
      shutdown_l_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (idle_cnt_q != IDLE_CW'(IDLE_TIMEOUT)) idle_cnt_d = idle_cnt_q + IDLE_CW'(1);
      if (idle_cnt_d == IDLE_CW'(IDLE_TIMEOUT)) shutdown_l_d = 1'b0;
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q   <= '0;
      shutdown_l_q <= 1'b1;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      shutdown_l_q <= shutdown_l_d;
    end
  end

  assign shutdown_l = shutdown_l_q;
`else
  assign shutdown_l = 1'b1;

  // IDLE_TIMEOUT only sizes the auto-shutdown counter. This empty block keeps
  // the parameter referenced when that logic is compiled out.
  if (IDLE_TIMEOUT < 1) begin : g_idle_timeout_ref
  end
`endif

endmodule

// File: tb/tb_key_tone_ctrl.sv
`timescale 1ns/1ps
// Directed bench for key_tone_ctrl (NUM_KEYS=4, DIV_W=10, VOL_W=8).
// Expected values are queued when stimulus is applied and popped when the
// corresponding output is sampled on the falling edge.
module tb_key_tone_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keys;
  logic [7:0] volume;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [9:0] cfg_div;
  logic       ain, gain, shutdown_l, playing;
  logic [1:0] note_idx;

`ifdef KEY_TONE_AUTO_SHUTDOWN_EN
  localparam logic SHDN_AFTER_IDLE = 1'b0;
`else
  localparam logic SHDN_AFTER_IDLE = 1'b1;
`endif

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sbQ[$];
  int        nCompared   = 0;
  int        nMismatched = 0;
  int        cyc;
  logic [7:0] vlatModel;
  int        entryCyc;
  logic      lastExp;

  key_tone_ctrl #(
    .NUM_KEYS(4), .DIV_W(10), .VOL_W(8), .IDLE_TIMEOUT(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .volume(volume),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_div(cfg_div),
    .ain(ain), .gain(gain), .shutdown_l(shutdown_l),
    .playing(playing), .note_idx(note_idx)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle count since reset release and the volume latch that follows from
  // a PWM counter free-running from zero out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      vlatModel <= 8'd0;
    end else begin
      cyc <= cyc + 1;
      if ((cyc % 256) == 255) vlatModel <= volume;
    end
  end

  // Hard stop so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input string tag, input logic [31:0] val);
    sb_entry_t e;
    e.tag = tag;
    e.exp = val;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    sb_entry_t e;
    nCompared++;
    if (sbQ.size() == 0) begin
      nMismatched++;
      $error("[TB] FAIL sb_empty: observed %0h, required a queued expectation", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.exp) else begin
        nMismatched++;
        $error("[TB] FAIL %s: observed %0h required %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expectNow(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    pushExp(tag, exp);
    checkOutput(obs);
  endtask

  task automatic applyStimulus(input logic [3:0] k, input logic [7:0] vol,
                               input logic we, input logic [1:0] idx, input logic [9:0] dv);
    keys    = k;
    volume  = vol;
    cfg_we  = we;
    cfg_idx = idx;
    cfg_div = dv;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic writeDiv(input logic [1:0] idx, input logic [9:0] dv);
    applyStimulus(keys, volume, 1'b1, idx, dv);
    step(1);
    cfg_we = 1'b0;
  endtask

  // Square wave starts high on PLAY entry; first half lasts h0, later ones h1.
  function automatic logic toneHigh(input int t, input int h0, input int h1);
    if (t < h0) return 1'b1;
    return (((t - h0) / h1) % 2) == 1;
  endfunction

  // Per-cycle ain check while a note is held.
  task automatic runCheck(input string tag, input int n, input int h0, input int h1,
                          output logic lastE);
    logic e;
    e = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = toneHigh(cyc - entryCyc, h0, h1) && ((cyc % 256) < int'(vlatModel));
      pushExp(tag, {31'b0, e});
      step(1);
      checkOutput({31'b0, ain});
    end
    lastE = e;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000, 8'd255, 1'b0, 2'd0, 10'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values
    expectNow("rst_ain", 0, ain);
    expectNow("rst_gain", 1, gain);
    expectNow("rst_shdn", 1, shutdown_l);
    expectNow("rst_playing", 0, playing);
    expectNow("rst_note", 0, note_idx);

    // Keys with an empty table do nothing
    applyStimulus(4'b1111, 8'd255, 1'b0, 2'd0, 10'd0);
    step(5);
    expectNow("empty_tab_playing", 0, playing);
    expectNow("empty_tab_note", 0, note_idx);
    applyStimulus(4'b0000, 8'd255, 1'b0, 2'd0, 10'd0);
    step(3);

    writeDiv(2'd1, 10'd5);
    while (cyc < 260) step(1);
    expectNow("idle_shdn", {31'b0, SHDN_AFTER_IDLE}, shutdown_l);

    // Two-edge latency from first sample
    applyStimulus(4'b0010, 8'd255, 1'b0, 2'd0, 10'd0);
    step(1);
    expectNow("lat_k", 0, playing);
    step(1);
    expectNow("lat_k1", 0, playing);
    step(1);
    expectNow("lat_k2", 1, playing);
    expectNow("lat_note", 1, note_idx);
    expectNow("play_shdn", 1, shutdown_l);
    entryCyc = cyc;

    // Tone period 10, full volume, then volume 64 and 0
    runCheck("tone5_v255", 40, 5, 5, lastExp);
    applyStimulus(4'b0010, 8'd64, 1'b0, 2'd0, 10'd0);
    runCheck("tone5_v64", 300, 5, 5, lastExp);
    applyStimulus(4'b0010, 8'd0, 1'b0, 2'd0, 10'd0);
    runCheck("tone5_v0", 300, 5, 5, lastExp);
    applyStimulus(4'b0010, 8'd255, 1'b0, 2'd0, 10'd0);
    step(260);

    // Release of the latched key returns to IDLE
    applyStimulus(4'b0000, 8'd255, 1'b0, 2'd0, 10'd0);
    step(2);
    expectNow("rel_hold", 1, playing);
    step(1);
    expectNow("rel_idle", 0, playing);
    step(1);
    expectNow("rel_ain", 0, ain);

    // Priority and ignoring other keys
    writeDiv(2'd2, 10'd7);
    applyStimulus(4'b0110, 8'd255, 1'b0, 2'd0, 10'd0);
    step(3);
    expectNow("prio_playing", 1, playing);
    expectNow("prio_note", 1, note_idx);
    applyStimulus(4'b0010, 8'd255, 1'b0, 2'd0, 10'd0);
    step(5);
    expectNow("rel_other_playing", 1, playing);
    expectNow("rel_other_note", 1, note_idx);
    applyStimulus(4'b0000, 8'd255, 1'b0, 2'd0, 10'd0);
    step(3);
    expectNow("rel1_playing", 0, playing);
    step(1);
    expectNow("rel1_ain", 0, ain);

    // Zero-divider key is not a candidate; lower key pressed in PLAY is ignored
    applyStimulus(4'b0101, 8'd255, 1'b0, 2'd0, 10'd0);
    step(3);
    expectNow("zdiv_playing", 1, playing);
    expectNow("zdiv_note", 2, note_idx);
    applyStimulus(4'b0111, 8'd255, 1'b0, 2'd0, 10'd0);
    step(4);
    expectNow("ign_lower_note", 2, note_idx);
    expectNow("ign_lower_playing", 1, playing);
    applyStimulus(4'b0000, 8'd255, 1'b0, 2'd0, 10'd0);
    step(4);
    expectNow("rel2_playing", 0, playing);

    // Write on the entry edge: entry keeps 5, the wrap picks up 9
    applyStimulus(4'b0010, 8'd255, 1'b0, 2'd0, 10'd0);
    step(2);
    applyStimulus(4'b0010, 8'd255, 1'b1, 2'd1, 10'd9);
    step(1);
    cfg_we = 1'b0;
    expectNow("coinc_playing", 1, playing);
    entryCyc = cyc;
    runCheck("tone5_then9", 60, 5, 9, lastExp);
    for (int i = 0; i < 40; i++) begin
      if (lastExp) break;
      runCheck("tone5_then9", 1, 5, 9, lastExp);
    end

    // Asynchronous reset while ain is high
    #2;
    rst_n = 1'b0;
    #1;
    expectNow("async_ain", 0, ain);
    expectNow("async_playing", 0, playing);
    expectNow("async_note", 0, note_idx);
    expectNow("async_gain", 1, gain);
    expectNow("async_shdn", 1, shutdown_l);
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    expectNow("tab_cleared_playing", 0, playing);

    // Muting the playing entry does not stop the note
    writeDiv(2'd3, 10'd4);
    applyStimulus(4'b1010, 8'd255, 1'b0, 2'd0, 10'd0);
    step(3);
    expectNow("k3_playing", 1, playing);
    expectNow("k3_note", 3, note_idx);
    writeDiv(2'd3, 10'd0);
    step(20);
    expectNow("mute_playing", 1, playing);
    expectNow("mute_note", 3, note_idx);
    applyStimulus(4'b0000, 8'd255, 1'b0, 2'd0, 10'd0);
    step(3);
    expectNow("mute_rel_playing", 0, playing);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
